// File: rtl/processor.sv
// Row generator: fills a 1024x(4x32) result memory with R[i][k] = sum_j (i+j)*(k-j),
// one step per clock, and exposes a registered, enable-gated read port.
module processor (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_data_valid,
    input  logic             stall,
    output logic             out_data_valid,
    input  logic [9:0]       BRAM_PORTB_0_addr,
    input  logic             BRAM_PORTB_0_clk,
    output logic [3:0][31:0] BRAM_PORTB_0_dout
);

    typedef enum logic {RUN, DONE} state_t;

    state_t           state, state_next;
    logic [9:0]       i;
    logic [1:0]       j;
    logic [3:0][31:0] acc;
    logic [3:0][31:0] sum;
    logic             step;
    logic             we;
    logic             unused_port_clk;

    logic [3:0][31:0] mem [1024] = '{default: '0};

    // Read port runs on clk; the separate port clock exists only for integration.
    assign unused_port_clk = BRAM_PORTB_0_clk;

    always_comb begin
        state_next = state;
        step       = 1'b0;
        we         = 1'b0;
        if (state == RUN && !stall) begin
            step = 1'b1;
            if (j == 2'd3) begin
                we = 1'b1;
                if (i == 10'd1023)
                    state_next = DONE;
            end
        end
    end

    // Low 32 bits of a product are the same for signed and unsigned operands.
    always_comb begin
        sum = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            sum[k] = (j == 2'd0 ? 32'd0 : acc[k])
                   + (32'(i) + 32'(j)) * (32'(k) - 32'(j));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state          <= RUN;
            i              <= '0;
            j              <= '0;
            acc            <= '0;
            out_data_valid <= 1'b0;
        end else begin
            state          <= state_next;
            out_data_valid <= (state_next == DONE);
            if (step) begin
                acc <= sum;
                j   <= j + 2'd1;
                if (j == 2'd3)
                    i <= i + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we && rstn)
            mem[i] <= sum;
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            BRAM_PORTB_0_dout <= '0;
        else if (in_data_valid)
            BRAM_PORTB_0_dout <= mem[BRAM_PORTB_0_addr];
    end

endmodule

// File: tb/tb_processor.sv
// Scoreboard bench for processor: expected rows are queued when a read is issued
// and compared against the read port one cycle later.
module tb_processor;

    typedef logic [3:0][31:0] row_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       in_data_valid = 1'b0;
    logic       stall = 1'b0;
    logic       out_data_valid;
    logic [9:0] addr = '0;
    row_t       dout;

    row_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   edges;

    int   probe_edge [3] = '{4, 9, 14};
    int   probe_addr [3] = '{0, 0, 5};
    bit   probe_zero [3] = '{1'b1, 1'b0, 1'b1};

    processor dut (
        .clk               (clk),
        .rstn              (rstn),
        .in_data_valid     (in_data_valid),
        .stall             (stall),
        .out_data_valid    (out_data_valid),
        .BRAM_PORTB_0_addr (addr),
        .BRAM_PORTB_0_clk  (clk),
        .BRAM_PORTB_0_dout (dout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic row_t model_row(input int a);
        row_t r;
        for (int k = 0; k < 4; k++)
            r[k] = 4 * a * k - 6 * a + 6 * k - 14;
        return r;
    endfunction

    task automatic compare_pop(input string tag);
        row_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no queued expectation expected one", tag);
        end else begin
            e = sb.pop_front();
            for (int k = 0; k < 4; k++)
                check($sformatf("%s.lane%0d", tag, k), dout[k], e[k]);
        end
    endtask

    task automatic read_row(input int a);
        in_data_valid = 1'b1;
        addr = 10'(a);
        sb.push_back(model_row(a));
        tick();
        in_data_valid = 1'b0;
        compare_pop($sformatf("row%0d", a));
    endtask

    // Counts edges from reset release until out_data_valid is seen high (-1 on timeout).
    task automatic run_until_done(input int stall_lo, input int stall_hi,
                                  input bit probes, output int n_done);
        int pidx;
        n_done = -1;
        for (int n = 1; n <= 6000; n++) begin
            stall = (n >= stall_lo && n < stall_hi);
            pidx = -1;
            if (probes)
                for (int p = 0; p < 3; p++)
                    if (probe_edge[p] == n) pidx = p;
            if (pidx >= 0) begin
                in_data_valid = 1'b1;
                addr = 10'(probe_addr[pidx]);
                sb.push_back(probe_zero[pidx] ? row_t'('0) : model_row(probe_addr[pidx]));
            end
            tick();
            if (pidx >= 0) begin
                in_data_valid = 1'b0;
                compare_pop($sformatf("probe_e%0d_r%0d", n, probe_addr[pidx]));
            end
            if (out_data_valid) begin
                n_done = n;
                break;
            end
        end
        stall = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        check("reset_odv", out_data_valid, 0);
        sb.push_back('0);
        compare_pop("reset_dout");

        rstn = 1'b1;
        run_until_done(0, 0, 1'b1, edges);
        check("done_edges_nostall", edges, 4096);
        check("done_odv", out_data_valid, 1);
        for (int a = 0; a < 50; a++)
            read_row(a);

        addr = 10'd7;
        sb.push_back(model_row(49));
        tick();
        compare_pop("frozen_a7");
        addr = 10'd300;
        sb.push_back(model_row(49));
        tick();
        compare_pop("frozen_a300");
        read_row(2);

        stall = 1'b1;
        repeat (5) tick();
        stall = 1'b0;
        check("done_stall_odv", out_data_valid, 1);
        read_row(1023);

        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("pulse_odv", out_data_valid, 0);
        sb.push_back('0);
        compare_pop("pulse_dout");

        run_until_done(40, 80, 1'b0, edges);
        check("done_edges_stall40", edges, 4136);
        for (int a = 0; a < 1024; a++)
            read_row(a);

        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        run_until_done(4096, 4103, 1'b0, edges);
        check("done_edges_laststall", edges, 4103);
        read_row(0);
        read_row(511);
        read_row(1023);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
